// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: fetch-side handshake in, ALU op handshake out.
// The stage itself uses the slave view; the producer/consumer side uses master.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_con;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, alu_con, alu_a, alu_b, rd, rd_we, illegal
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, alu_con, alu_a, alu_b, rd, rd_we, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM/LUI/AUIPC decoder feeding the ALU through a 2-entry skid FIFO.
// Every output comes from a registered entry; nothing flows straight from input to output.
module alu_issue_stage #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_stage_if.slave bus
);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [3:0]      dec_con;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_legal;
  logic            unused_rs1_field;

  assign opcode = bus.instr[6:0];
  assign f3     = bus.instr[14:12];
  assign f7     = bus.instr[31:25];
  assign imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_u  = {bus.instr[31:12], 12'b0};
  assign unused_rs1_field = ^bus.instr[19:15];

  always_comb begin
    dec_con   = 4'b0000;
    dec_a     = '0;
    dec_b     = '0;
    dec_legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a     = bus.rs1_data;
        dec_b     = bus.rs2_data;
        dec_legal = (f7 == 7'b0) || ((f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101));
        case (f3)
          3'b000: dec_con = f7[5] ? 4'b0001 : 4'b0000;
          3'b001: begin dec_con = 4'b1010; dec_b = {27'b0, bus.rs2_data[4:0]}; end
          3'b010: dec_con = 4'b0101;
          3'b011: dec_con = 4'b0110;
          3'b100: dec_con = 4'b0100;
          3'b101: begin dec_con = f7[5] ? 4'b1011 : 4'b1100; dec_b = {27'b0, bus.rs2_data[4:0]}; end
          3'b110: dec_con = 4'b0011;
          default: dec_con = 4'b0010;
        endcase
      end
      OPC_OPIMM: begin
        dec_a = bus.rs1_data;
        dec_b = imm_i;
        case (f3)
          3'b000: begin dec_con = 4'b0000; dec_legal = 1'b1; end
          3'b001: begin
            dec_con   = 4'b1010;
            dec_b     = {27'b0, bus.instr[24:20]};
            dec_legal = (f7 == 7'b0);
          end
          3'b010: begin dec_con = 4'b0101; dec_legal = 1'b1; end
          3'b011: begin dec_con = 4'b0110; dec_legal = 1'b1; end
          3'b100: begin dec_con = 4'b0100; dec_legal = 1'b1; end
          3'b101: begin
            dec_con   = f7[5] ? 4'b1011 : 4'b1100;
            dec_b     = {27'b0, bus.instr[24:20]};
            dec_legal = (f7 == 7'b0) || (f7 == F7_ALT);
          end
          3'b110: begin dec_con = 4'b0011; dec_legal = 1'b1; end
          default: begin dec_con = 4'b0010; dec_legal = 1'b1; end
        endcase
      end
      OPC_LUI: begin
        dec_con   = 4'b1001;
        dec_b     = imm_u;
        dec_legal = 1'b1;
      end
      OPC_AUIPC: begin
        dec_con   = 4'b1000;
        dec_a     = bus.pc;
        dec_b     = imm_u;
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
    // Unsupported encodings travel down the pipe as inert bubbles tagged illegal.
    if (!dec_legal) begin
      dec_con = 4'b0000;
      dec_a   = '0;
      dec_b   = '0;
    end
  end

  logic [1:0]      count_reg;
  logic            rd_ptr_reg;
  logic            wr_ptr_reg;
  logic            push;
  logic            pop;
  logic [3:0]      con_reg [DEPTH];
  logic [XLEN-1:0] a_reg   [DEPTH];
  logic [XLEN-1:0] b_reg   [DEPTH];
  logic [4:0]      rd_reg  [DEPTH];
  logic            we_reg  [DEPTH];
  logic            ill_reg [DEPTH];

  assign bus.in_ready  = (count_reg != 2'd2);
  assign bus.out_valid = (count_reg != 2'd0);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic SLOT = 1'(gi);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          con_reg[gi] <= '0;
          a_reg[gi]   <= '0;
          b_reg[gi]   <= '0;
          rd_reg[gi]  <= '0;
          we_reg[gi]  <= 1'b0;
          ill_reg[gi] <= 1'b0;
        end else if (push && !bus.flush && wr_ptr_reg == SLOT) begin
          con_reg[gi] <= dec_con;
          a_reg[gi]   <= dec_a;
          b_reg[gi]   <= dec_b;
          rd_reg[gi]  <= bus.instr[11:7];
          we_reg[gi]  <= dec_legal && (bus.instr[11:7] != 5'd0);
          ill_reg[gi] <= !dec_legal;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else if (bus.flush) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // Stale slots are masked so an empty FIFO never shows a flushed or popped op.
  assign bus.alu_con = bus.out_valid ? con_reg[rd_ptr_reg] : 4'b0000;
  assign bus.alu_a   = bus.out_valid ? a_reg[rd_ptr_reg]   : '0;
  assign bus.alu_b   = bus.out_valid ? b_reg[rd_ptr_reg]   : '0;
  assign bus.rd      = bus.out_valid ? rd_reg[rd_ptr_reg]  : 5'd0;
  assign bus.rd_we   = bus.out_valid & we_reg[rd_ptr_reg];
  assign bus.illegal = bus.out_valid & ill_reg[rd_ptr_reg];
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus FIFO, flush and reset sequences.
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst_n;
  alu_issue_stage_if bus ();

  alu_issue_stage #(.DEPTH(2), .XLEN(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  con;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.instr    = instr;
    bus.pc       = pc;
    bus.rs1_data = rs1;
    bus.rs2_data = rs2;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, ".in_ready"},  32'(bus.in_ready),  32'd1);
    chk({nm, ".alu_con"},   32'(bus.alu_con),   32'd0);
    chk({nm, ".alu_a"},     bus.alu_a,          32'd0);
    chk({nm, ".alu_b"},     bus.alu_b,          32'd0);
    chk({nm, ".rd"},        32'(bus.rd),        32'd0);
    chk({nm, ".rd_we"},     32'(bus.rd_we),     32'd0);
    chk({nm, ".illegal"},   32'(bus.illegal),   32'd0);
  endtask

  initial begin
    //          instr          pc        rs1           rs2           con      a             b             rd  we ill
    vecs[0]  = '{32'hFFF00293, 32'h0,   32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFFFFFF, 5,  1, 0}; // addi x5,x0,-1
    vecs[1]  = '{32'h4020D1B3, 32'h0,   32'h80000000, 32'h00000123, 4'b1011, 32'h80000000, 32'h3,        3,  1, 0}; // sra
    vecs[2]  = '{32'h420081B3, 32'h0,   32'h1,        32'h2,        4'b0000, 32'h0,        32'h0,        3,  0, 1}; // sub f7 bad
    vecs[3]  = '{32'h12345097, 32'h100, 32'h5,        32'h6,        4'b1000, 32'h100,      32'h12345000, 1,  1, 0}; // auipc
    vecs[4]  = '{32'hABCDE037, 32'h40,  32'h5,        32'h6,        4'b1001, 32'h0,        32'hABCDE000, 0,  0, 0}; // lui x0
    vecs[5]  = '{32'h002083B3, 32'h0,   32'd10,       32'd20,       4'b0000, 32'd10,       32'd20,       7,  1, 0}; // add
    vecs[6]  = '{32'h402083B3, 32'h0,   32'd10,       32'd20,       4'b0001, 32'd10,       32'd20,       7,  1, 0}; // sub
    vecs[7]  = '{32'hFFB0B213, 32'h0,   32'h7,        32'h0,        4'b0110, 32'h7,        32'hFFFFFFFB, 4,  1, 0}; // sltiu
    vecs[8]  = '{32'h01F09313, 32'h0,   32'h1,        32'h0,        4'b1010, 32'h1,        32'h1F,       6,  1, 0}; // slli 31
    vecs[9]  = '{32'h41F09313, 32'h0,   32'h1,        32'h0,        4'b0000, 32'h0,        32'h0,        6,  0, 1}; // slli f7 bad
    vecs[10] = '{32'h4040D313, 32'h0,   32'hF0000000, 32'h0,        4'b1011, 32'hF0000000, 32'h4,        6,  1, 0}; // srai 4
    vecs[11] = '{32'h7F00F113, 32'h0,   32'h12345678, 32'h0,        4'b0010, 32'h12345678, 32'h7F0,      2,  1, 0}; // andi
    vecs[12] = '{32'h0000A083, 32'h0,   32'h9,        32'h9,        4'b0000, 32'h0,        32'h0,        1,  0, 1}; // lw
    vecs[13] = '{32'h403140B3, 32'h0,   32'h9,        32'h9,        4'b0000, 32'h0,        32'h0,        1,  0, 1}; // xor f7 bad
    vecs[14] = '{32'h003150B3, 32'h0,   32'hAAAA5555, 32'hFFFFFFE5, 4'b1100, 32'hAAAA5555, 32'h5,        1,  1, 0}; // srl

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) tick();
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_idle("post_reset");

    // Decode table: one push, check the head one cycle later, then pop.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      $display("txn %0d instr=%08h con=%04b a=%08h b=%08h rd=%0d we=%0b ill=%0b",
               i, vecs[i].instr, bus.alu_con, bus.alu_a, bus.alu_b, bus.rd, bus.rd_we, bus.illegal);
      chk($sformatf("v%0d.out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d.alu_con", i),   32'(bus.alu_con),   32'(vecs[i].con));
      chk($sformatf("v%0d.alu_a", i),     bus.alu_a,          vecs[i].a);
      chk($sformatf("v%0d.alu_b", i),     bus.alu_b,          vecs[i].b);
      chk($sformatf("v%0d.rd", i),        32'(bus.rd),        32'(vecs[i].rd));
      chk($sformatf("v%0d.rd_we", i),     32'(bus.rd_we),     32'(vecs[i].we));
      chk($sformatf("v%0d.illegal", i),   32'(bus.illegal),   32'(vecs[i].ill));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk($sformatf("v%0d.drained", i), 32'(bus.out_valid), 32'd0);
    end

    // Backpressure: three ADDI x1,x1,1 ops distinguished by rs1, consumer stalled.
    drive(32'h00108093, 32'h0, 32'h11, 32'h0);
    bus.in_valid = 1'b1;
    tick();
    $display("txn bp push1 head_a=%08h in_ready=%0b", bus.alu_a, bus.in_ready);
    chk("bp1.in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp1.head_a",   bus.alu_a,         32'h11);
    drive(32'h00108093, 32'h0, 32'h22, 32'h0);
    tick();
    $display("txn bp push2 head_a=%08h in_ready=%0b", bus.alu_a, bus.in_ready);
    chk("bp2.in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp2.head_a",   bus.alu_a,         32'h11);
    drive(32'h00108093, 32'h0, 32'h33, 32'h0);
    tick();
    $display("txn bp hold head_a=%08h in_ready=%0b", bus.alu_a, bus.in_ready);
    chk("bp3.in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp3.head_a",   bus.alu_a,         32'h11);
    chk("bp3.head_b",   bus.alu_b,         32'h1);
    bus.out_ready = 1'b1;
    tick();
    $display("txn bp pop1 head_a=%08h in_ready=%0b", bus.alu_a, bus.in_ready);
    chk("bp4.head_a",   bus.alu_a,         32'h22);
    chk("bp4.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    $display("txn bp pop2 head_a=%08h", bus.alu_a);
    chk("bp5.out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp5.head_a",    bus.alu_a,          32'h33);
    tick();
    bus.out_ready = 1'b0;
    $display("txn bp pop3 out_valid=%0b", bus.out_valid);
    chk_idle("bp_empty");

    // Flush with simultaneous push and pop at count=1.
    drive(32'h002083B3, 32'h0, 32'hAA, 32'hBB);
    bus.in_valid = 1'b1;
    tick();
    chk("fl.pre_valid", 32'(bus.out_valid), 32'd1);
    drive(32'h402083B3, 32'h0, 32'hCC, 32'hDD);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    $display("txn flush out_valid=%0b alu_a=%08h", bus.out_valid, bus.alu_a);
    chk_idle("flush");
    tick();
    chk("fl.still_empty", 32'(bus.out_valid), 32'd0);
    drive(32'hFFF00293, 32'h0, 32'h0, 32'h0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    $display("txn post_flush push head_b=%08h rd=%0d", bus.alu_b, bus.rd);
    chk("fl.next_b",  bus.alu_b,   32'hFFFFFFFF);
    chk("fl.next_rd", 32'(bus.rd), 32'd5);
    chk("fl.next_cnt1_ready", 32'(bus.in_ready), 32'd1);

    // Asynchronous reset while full.
    drive(32'h12345097, 32'h100, 32'h0, 32'h0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("rs.full_ready", 32'(bus.in_ready),  32'd0);
    chk("rs.full_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn async_reset out_valid=%0b in_ready=%0b", bus.out_valid, bus.in_ready);
    chk_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_idle("after_async_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
